mac_vec_acc: RTL and testbench

MAC_VEC_ACC -- requirements
Module: mac_vec_acc

---
 rtl/mac_pkg.sv | 30 +++
 rtl/mac_lane_mul.sv | 46 ++++
 rtl/mac_vec_acc.sv | 125 ++++++++++++
 tb/tb_mac_vec_acc.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - Q-format defaults and saturation helpers shared by the MAC datapath
package mac_pkg;

    localparam int Q_DATA_WIDTH = 16;
    localparam int Q_FRAC_BITS  = 12;

    function automatic logic signed [63:0] sat_hi(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_lo(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    function automatic logic signed [63:0] sat_value(input logic signed [63:0] v,
                                                     input int                 width);
        if (v > sat_hi(width)) begin
            return sat_hi(width);
        end
        if (v < sat_lo(width)) begin
            return sat_lo(width);
        end
        return v;
    endfunction

    function automatic logic sat_flag(input logic signed [63:0] v, input int width);
        return (v > sat_hi(width)) || (v < sat_lo(width));
    endfunction

endpackage

// File: rtl/mac_lane_mul.sv
// rtl/mac_lane_mul.sv - one lane: signed multiply, optional half-LSB bias, arithmetic shift, register
module mac_lane_mul
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = Q_DATA_WIDTH,
    parameter int FRAC_BITS  = Q_FRAC_BITS,
    parameter int ROUND      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [2*DATA_WIDTH:0] prod_o
);

    // One spare bit keeps the rounding bias from overflowing the full product.
    localparam int PW      = 2 * DATA_WIDTH + 1;
    localparam int HALF_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic signed [PW-1:0] BIAS =
        (ROUND != 0 && FRAC_BITS > 0) ? (PW'(1) << HALF_SH) : '0;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] full;
    logic signed [PW-1:0] biased;
    logic signed [PW-1:0] prod_d;
    logic        [PW-1:0] prod_q;

    assign a_ext  = PW'($signed(a_i));
    assign b_ext  = PW'($signed(b_i));
    assign full   = a_ext * b_ext;
    assign biased = full + BIAS;
    assign prod_d = biased >>> FRAC_BITS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
        end else if (en_i) begin
            prod_q <= prod_d;
        end
    end

    assign prod_o = prod_q;

endmodule

// File: rtl/mac_vec_acc.sv
// rtl/mac_vec_acc.sv - LANES-wide fixed-point dot-product accumulator with saturated, stallable output
module mac_vec_acc
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = Q_DATA_WIDTH,
    parameter int FRAC_BITS  = Q_FRAC_BITS,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int ROUND      = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] a_vec,
    input  logic [LANES*DATA_WIDTH-1:0] b_vec,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       result,
    output logic                        sat
);

    localparam int LW     = 2 * DATA_WIDTH + 1;
    localparam int LEVELS = $clog2(LANES);

    logic                        stall;
    logic                        s1_en;
    logic                        s1_valid_q;
    logic                        s1_last_q;
    logic [LW-1:0]               lane_q [LANES];
    logic signed [ACC_WIDTH-1:0] tree_sum;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic                        out_valid_q;
    logic                        out_valid_d;
    logic [DATA_WIDTH-1:0]       result_q;
    logic [DATA_WIDTH-1:0]       result_d;
    logic                        sat_q;
    logic                        sat_d;

    // A held result freezes the whole pipe so no accepted beat is ever dropped.
    assign stall    = out_valid_q & ~out_ready;
    assign s1_en    = ~stall;
    assign in_ready = ~stall;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane_mul #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .ROUND      (ROUND)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en_i   (s1_en),
            .a_i    (a_vec[i*DATA_WIDTH +: DATA_WIDTH]),
            .b_i    (b_vec[i*DATA_WIDTH +: DATA_WIDTH]),
            .prod_o (lane_q[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else if (s1_en) begin
            s1_valid_q <= in_valid;
            s1_last_q  <= in_valid & in_last;
        end
    end

    // Binary adder tree: level 0 holds the sign-extended lanes, each level halves the count.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic signed [ACC_WIDTH-1:0] v [LANES >> l];
        for (genvar j = 0; j < (LANES >> l); j++) begin : g_node
            if (l == 0) begin : g_leaf
                assign v[j] = ACC_WIDTH'($signed(lane_q[j]));
            end else begin : g_add
                assign v[j] = g_lvl[l-1].v[2*j] + g_lvl[l-1].v[2*j+1];
            end
        end
    end

    assign tree_sum = g_lvl[LEVELS].v[0];
    assign acc_sum  = acc_q + tree_sum;

    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        sat_d       = sat_q;
        if (!stall) begin
            out_valid_d = s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    acc_d    = '0;
                    result_d = DATA_WIDTH'(sat_value(64'(acc_sum), DATA_WIDTH));
                    sat_d    = sat_flag(64'(acc_sum), DATA_WIDTH);
                end else begin
                    acc_d = acc_sum;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sat_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_mac_vec_acc.sv
// tb/tb_mac_vec_acc.sv - self-checking bench for mac_vec_acc, truncating and rounding builds side by side
module tb_mac_vec_acc;

    localparam int DW = 16;
    localparam int FB = 12;
    localparam int LN = 4;
    localparam int AW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_last;
    logic             out_ready;
    logic [LN*DW-1:0] a_vec;
    logic [LN*DW-1:0] b_vec;
    logic             in_ready;
    logic             out_valid;
    logic [DW-1:0]    result0;
    logic             sat0;
    logic             in_ready1;
    logic             out_valid1;
    logic [DW-1:0]    result1;
    logic             sat1;

    always #5 clk = ~clk;

    mac_vec_acc #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .LANES(LN), .ACC_WIDTH(AW), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_vec(a_vec), .b_vec(b_vec), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .result(result0), .sat(sat0)
    );

    mac_vec_acc #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .LANES(LN), .ACC_WIDTH(AW), .ROUND(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a_vec(a_vec), .b_vec(b_vec), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .result(result1), .sat(sat1)
    );

    typedef struct {
        logic [15:0] r0;
        logic        s0;
        logic [15:0] r1;
        logic        s1;
    } exp_t;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        int          nb;
        logic [15:0] r0;
        logic        s0;
        logic [15:0] r1;
        logic        s1;
    } vec_t;

    exp_t   sb[$];
    vec_t   tbl[6];
    longint part0 = 0;
    longint part1 = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    int     n_hs = 0;
    logic   fired = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // Exact real-number semantics: each lane product scaled by 2^-FB, floored (optionally after +0.5 LSB).
    function automatic longint beat_sum(input logic [63:0] a, input logic [63:0] b, input bit rnd);
        longint s;
        longint p;
        logic [15:0] la;
        logic [15:0] lb;
        s = 0;
        for (int i = 0; i < LN; i++) begin
            la = a[i*DW +: DW];
            lb = b[i*DW +: DW];
            p  = longint'($signed(la)) * longint'($signed(lb));
            s += floor_div(p + (rnd ? longint'(2 ** (FB - 1)) : 0), longint'(2 ** FB));
        end
        return s;
    endfunction

    function automatic void clamp(input longint v, output logic [15:0] r, output logic s);
        if (v > 32767) begin r = 16'h7fff; s = 1'b1; end
        else if (v < -32768) begin r = 16'h8000; s = 1'b1; end
        else begin r = 16'(v); s = 1'b0; end
    endfunction

    task automatic tick();
        logic acc;
        exp_t e;
        #1;
        acc = in_valid & in_ready;
        if (out_valid && out_ready) begin
            n_hs++;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_result: got %0h with no vector pending", result0);
            end else begin
                e = sb.pop_front();
                chk("result_trunc", result0, e.r0);
                chk("sat_trunc", sat0, e.s0);
                chk("result_round", result1, e.r1);
                chk("sat_round", sat1, e.s1);
            end
        end
        @(posedge clk);
        fired = acc;
        if (acc) begin
            part0 += beat_sum(a_vec, b_vec, 1'b0);
            part1 += beat_sum(a_vec, b_vec, 1'b1);
            if (in_last) begin
                clamp(part0, e.r0, e.s0);
                clamp(part1, e.r1, e.s1);
                sb.push_back(e);
                part0 = 0;
                part1 = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result0, 0);
        chk("reset_sat", sat0, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        part0 = 0;
        part1 = 0;
    endtask

    task automatic send_vec(input logic [63:0] a, input logic [63:0] b, input int nb);
        int g;
        for (int k = 0; k < nb; k++) begin
            a_vec = a;
            b_vec = b;
            in_valid = 1'b1;
            in_last = (k == nb - 1);
            g = 0;
            do begin
                tick();
                g++;
            end while (!fired && g < 20);
            if (!fired) begin
                n_chk++;
                $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int g;
        in_valid = 1'b0;
        out_ready = 1'b1;
        g = 0;
        while (sb.size() > 0 && g < 30) begin
            tick();
            g++;
        end
        chk("drain_empty", sb.size(), 0);
        out_ready = 1'b0;
    endtask

    function automatic logic [63:0] rnd_vec();
        logic [63:0] v;
        for (int i = 0; i < LN; i++) begin
            if ($urandom_range(0, 2) == 0) v[i*DW +: DW] = 16'($urandom_range(0, 65535));
            else v[i*DW +: DW] = 16'(int'($urandom_range(0, 4095)) - 2048);
        end
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        int hs0;
        int nb;
        int g;

        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        a_vec = '0;
        b_vec = '0;

        tbl[0] = '{"one_by_one",  {4{16'h1000}}, {4{16'h1000}}, 1, 16'h4000, 1'b0, 16'h4000, 1'b0};
        tbl[1] = '{"neg_sat",     {4{16'h1000}}, {4{16'hF000}}, 3, 16'h8000, 1'b1, 16'h8000, 1'b1};
        tbl[2] = '{"after_clear", {4{16'h1000}}, {4{16'h0400}}, 1, 16'h1000, 1'b0, 16'h1000, 1'b0};
        tbl[3] = '{"half_lsb",    64'h0001,      64'h0800,      1, 16'h0000, 1'b0, 16'h0001, 1'b0};
        tbl[4] = '{"neg_half",    64'hFFFF,      64'h0800,      1, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
        tbl[5] = '{"pos_sat",     {4{16'h7FFF}}, {4{16'h7FFF}}, 4, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1};

        #2;
        apply_reset();

        for (int t = 0; t < 6; t++) begin
            out_ready = 1'b0;
            send_vec(tbl[t].a, tbl[t].b, tbl[t].nb);
            chk({tbl[t].name, "_not_early"}, out_valid, 0);
            tick();
            chk({tbl[t].name, "_latency"}, out_valid, 1);
            chk({tbl[t].name, "_r_trunc"}, result0, tbl[t].r0);
            chk({tbl[t].name, "_s_trunc"}, sat0, tbl[t].s0);
            chk({tbl[t].name, "_r_round"}, result1, tbl[t].r1);
            chk({tbl[t].name, "_s_round"}, sat1, tbl[t].s1);
            drain();
        end

        // Output held for 5 cycles while a new last beat waits at the input.
        send_vec({4{16'h1000}}, {4{16'h1000}}, 1);
        tick();
        a_vec = {4{16'h1000}};
        b_vec = {4{16'h0400}};
        in_valid = 1'b1;
        in_last = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_in_ready", in_ready, 0);
            chk("stall_no_accept", fired, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_result", result0, 16'h4000);
        end
        out_ready = 1'b1;
        tick();
        chk("release_accept", fired, 1);
        in_valid = 1'b0;
        in_last = 1'b0;
        tick();
        chk("after_stall_result", result0, 16'h1000);
        drain();

        // Back-to-back single-beat vectors: one result per cycle.
        out_ready = 1'b1;
        hs0 = n_hs;
        for (int i = 0; i < 6; i++) begin
            a_vec = rnd_vec();
            b_vec = rnd_vec();
            in_valid = 1'b1;
            in_last = 1'b1;
            tick();
            chk("b2b_accept", fired, 1);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        tick();
        tick();
        chk("b2b_rate", n_hs - hs0, 6);
        drain();

        // Reset in the middle of a 4-beat vector discards the partial sum.
        a_vec = {4{16'h1000}};
        b_vec = {4{16'h7000}};
        in_valid = 1'b1;
        in_last = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        apply_reset();
        send_vec({4{16'h1000}}, {4{16'h1000}}, 1);
        tick();
        chk("reset_fresh_result", result0, 16'h4000);
        chk("reset_fresh_sat", sat0, 0);
        drain();

        // Random vectors with random input gaps and output back-pressure.
        for (int v = 0; v < 25; v++) begin
            nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) begin
                ra = rnd_vec();
                rb = rnd_vec();
                a_vec = ra;
                b_vec = rb;
                in_last = (k == nb - 1);
                g = 0;
                do begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    out_ready = ($urandom_range(0, 2) != 0);
                    tick();
                    g++;
                end while (!fired && g < 50);
                if (!fired) begin
                    n_chk++;
                    $display("FAIL rand_accept_timeout: got no accept expected accept within 50 cycles");
                end
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
